fetch_ctrl: RTL

Instruction fetch controller that closes the loop around the program counter register. It reads the current `pc`, fetches the word at that address from instruction memory over a req/ack handshake, and presents it to decode over a valid/ready handshake. It drives `nextPc` every cycle: hold, advance by 4, or load a redirect target. It sits between the PC register, instruction memory and the decode stage.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch controller state encoding and PC constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        START,
        FETCH,
        DELIVER,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'd100;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC register's next value, fetches
// from instruction memory over req/ack and holds one instruction for decode.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        pc,
    output logic [31:0]        nextPc,
    output logic               imemReq,
    output logic [31:0]        imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               redirect,
    input  logic [31:0]        redirectPc,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instrPc,
    output logic               instrValid,
    input  logic               instrReady
);

    fetch_state_t       state_q;
    logic               imemReq_q;
    logic               instrValid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [31:0]        instrPc_q;
    logic [31:0]        discardAddr_q;
    logic               transfer;

    assign transfer   = instrValid_q & instrReady;
    assign imemReq    = imemReq_q;
    assign instrValid = instrValid_q;
    assign instr      = instr_q;
    assign instrPc    = instrPc_q;

    // The abandoned request keeps its original address until memory acks it.
    assign imemAddr = (state_q == DISCARD) ? discardAddr_q : pc;

    // Next PC selection: redirect wins everywhere except START.
    always_comb begin
        nextPc = pc;
        if (state_q == START) begin
            nextPc = RESET_PC;
        end else if (redirect) begin
            nextPc = redirectPc;
        end else if (state_q == DELIVER && transfer) begin
            nextPc = pc + INSTR_BYTES;
        end
    end

    // Fetch FSM with registered request, valid and instruction register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= START;
            imemReq_q     <= 1'b0;
            instrValid_q  <= 1'b0;
            instr_q       <= '0;
            instrPc_q     <= '0;
            discardAddr_q <= '0;
        end else begin
            case (state_q)
                START: begin
                    state_q   <= FETCH;
                    imemReq_q <= 1'b1;
                end
                FETCH: begin
                    if (redirect) begin
                        // Ack in the same cycle closes the request; otherwise
                        // it stays outstanding and its data must be dropped.
                        if (!imemAck) begin
                            state_q       <= DISCARD;
                            discardAddr_q <= pc;
                        end
                    end else if (imemAck) begin
                        instr_q      <= imemData;
                        instrPc_q    <= pc;
                        instrValid_q <= 1'b1;
                        imemReq_q    <= 1'b0;
                        state_q      <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (redirect || transfer) begin
                        instrValid_q <= 1'b0;
                        imemReq_q    <= 1'b1;
                        state_q      <= FETCH;
                    end
                end
                DISCARD: begin
                    // A further redirect only retargets nextPc; the ack of
                    // the abandoned request always ends the discard.
                    if (imemAck) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q   <= START;
                    imemReq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
